// File: rtl/game_pkg.sv
// Shared game encodings and board geometry.
// Used by the barrel launcher, barrel movers and renderer.
package game_pkg;

   localparam int BOTTOM_BOARD = 461;
   localparam int LEFT_BOARD   = 5;
   localparam int BARREL_H     = 24;

   typedef enum logic [1:0] {
      B_INITIAL = 2'b00,
      B_ROLLING = 2'b01,
      B_FALLING = 2'b10
   } barrel_st_t;

   typedef enum logic [1:0] {
      DK_IDLE  = 2'b00,
      DK_GRAB  = 2'b01,
      DK_THROW = 2'b10
   } dk_st_t;

endpackage

// File: rtl/barrel_launcher_if.sv
// Launcher <-> barrel slots bus: packed positions/states in,
// per-slot start and retire pulses out.
interface barrel_launcher_if #(
   parameter int N = 4
);
   logic [10*N-1:0] barrel_x;
   logic [9*N-1:0]  barrel_y;
   logic [2*N-1:0]  barrel_state;
   logic [N-1:0]    barrel_start;
   logic [N-1:0]    barrel_rst;

   modport master (
      input  barrel_x,
      input  barrel_y,
      input  barrel_state,
      output barrel_start,
      output barrel_rst
   );

   modport slave (
      output barrel_x,
      output barrel_y,
      output barrel_state,
      input  barrel_start,
      input  barrel_rst
   );
endinterface

// File: rtl/barrel_slot_picker.sv
// Round-robin free-slot picker: free mask + ptr -> found, idx.
// Rotates by ptr, takes the lowest set bit, then unrotates.
module barrel_slot_picker #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  free,
   input  logic [PW-1:0] ptr,
   output logic          found,
   output logic [PW-1:0] idx
);

   logic [N-1:0] rot;
   int           off;

   always_comb begin
      rot   = '0;
      found = 1'b0;
      off   = 0;
      for (int j = 0; j < N; j++)
         rot[j] = free[(j + int'(ptr)) % N];
      for (int j = N - 1; j >= 0; j--) begin
         if (rot[j]) begin
            found = 1'b1;
            off   = j;
         end
      end
      idx = PW'((off + int'(ptr)) % N);
   end

endmodule

// File: rtl/barrel_launcher.sv
// DK throw sequencer: times IDLE/GRAB/THROW, fires one start pulse
// per throw into a round-robin free slot and retires exited barrels.
// Ports: clk, rst (sync, active high), game_active, over,
// bus (barrel x/y/state in, start/rst out), dk_state, live_count.
module barrel_launcher
   import game_pkg::*;
#(
   parameter int         N_BARRELS       = 4,
   parameter int         LAUNCH_INTERVAL = 120,
   parameter int         GRAB_TICKS      = 16,
   parameter int         THROW_TICKS     = 16,
   parameter logic [9:0] RETIRE_X        = 10'(LEFT_BOARD),
   parameter logic [8:0] RETIRE_Y        = 9'(BOTTOM_BOARD - BARREL_H)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              game_active,
   input  logic              over,
   barrel_launcher_if.master bus,
   output logic [1:0]        dk_state,
   output logic [3:0]        live_count
);

   localparam int N   = N_BARRELS;
   localparam int PW  = (N > 1) ? $clog2(N) : 1;
   localparam int M1  = (LAUNCH_INTERVAL > GRAB_TICKS)
                        ? LAUNCH_INTERVAL : GRAB_TICKS;
   localparam int CM  = (M1 > THROW_TICKS) ? M1 : THROW_TICKS;
   localparam int CW  = $clog2(CM);

   dk_st_t          st, st_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [PW-1:0]   sel, sel_n;
   logic [PW-1:0]   ptr, ptr_n;
   logic [N-1:0]    start_n;
   logic [N-1:0]    retire_now;
   logic [N-1:0]    free;
   logic            found;
   logic [PW-1:0]   idx;
   logic [3:0]      lc_n;
   logic            abort;

   assign abort    = over | ~game_active;
   assign dk_state = st;

   // A slot is free only if empty and not in any retire phase.
   always_comb begin
      retire_now = '0;
      free       = '0;
      lc_n       = '0;
      for (int i = 0; i < N; i++) begin
         retire_now[i] = (bus.barrel_state[2*i +: 2] != B_INITIAL)
                       && (bus.barrel_y[9*i +: 9] >= RETIRE_Y)
                       && (bus.barrel_x[10*i +: 10] <= RETIRE_X);
         free[i] = (bus.barrel_state[2*i +: 2] == B_INITIAL)
                 && !bus.barrel_rst[i] && !retire_now[i];
         lc_n = lc_n
              + {3'b000, bus.barrel_state[2*i +: 2] != B_INITIAL};
      end
   end

   barrel_slot_picker #(
      .N  (N),
      .PW (PW)
   ) u_picker (
      .free  (free),
      .ptr   (ptr),
      .found (found),
      .idx   (idx)
   );

   always_comb begin
      st_n    = st;
      cnt_n   = cnt;
      sel_n   = sel;
      ptr_n   = ptr;
      start_n = '0;
      if (abort) begin
         st_n  = DK_IDLE;
         cnt_n = '0;
      end else begin
         unique case (st)
            DK_IDLE: begin
               // Saturate and wait here until some slot frees up.
               if (cnt == CW'(LAUNCH_INTERVAL - 1)) begin
                  if (found) begin
                     sel_n = idx;
                     cnt_n = '0;
                     st_n  = DK_GRAB;
                  end
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            DK_GRAB: begin
               if (cnt == CW'(GRAB_TICKS - 1)) begin
                  // A slot taken meanwhile gives an empty throw.
                  start_n[sel] = free[sel];
                  ptr_n = (sel == PW'(N - 1)) ? '0 : sel + PW'(1);
                  cnt_n = '0;
                  st_n  = DK_THROW;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            DK_THROW: begin
               if (cnt == CW'(THROW_TICKS - 1)) begin
                  cnt_n = '0;
                  st_n  = DK_IDLE;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            default: begin
               cnt_n = '0;
               st_n  = DK_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st               <= DK_IDLE;
         cnt              <= '0;
         sel              <= '0;
         ptr              <= '0;
         bus.barrel_start <= '0;
         bus.barrel_rst   <= '0;
         live_count       <= '0;
      end else begin
         st               <= st_n;
         cnt              <= cnt_n;
         sel              <= sel_n;
         ptr              <= ptr_n;
         bus.barrel_start <= start_n;
         bus.barrel_rst   <= retire_now;
         live_count       <= lc_n;
      end
   end

endmodule

// File: tb/tb_barrel_launcher.sv
// Directed bench for barrel_launcher with default parameters.
// Each task drives one scenario and checks against hand values.
module tb_barrel_launcher;

   logic       clk = 1'b0;
   logic       rst;
   logic       game_active;
   logic       over;
   logic [1:0] dk_state;
   logic [3:0] live_count;

   int checks = 0;
   int passed = 0;

   barrel_launcher_if #(.N(4)) bus ();

   barrel_launcher dut (
      .clk         (clk),
      .rst         (rst),
      .game_active (game_active),
      .over        (over),
      .bus         (bus),
      .dk_state    (dk_state),
      .live_count  (live_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic set_slot(input int i, input logic [1:0] s,
                           input logic [9:0] x, input logic [8:0] y);
      bus.barrel_state[2*i +: 2] = s;
      bus.barrel_x[10*i +: 10]   = x;
      bus.barrel_y[9*i +: 9]     = y;
   endtask

   task automatic clear_slots();
      for (int i = 0; i < 4; i++) set_slot(i, 2'b00, 10'd100, 9'd100);
   endtask

   task automatic do_reset();
      clear_slots();
      game_active = 1'b1;
      over = 1'b0;
      rst = 1'b1;
      tick_n(2);
      rst = 1'b0;
   endtask

   // Ticks until a start pulse appears; got=0 when budget runs out.
   task automatic wait_start(input int budget, output logic [3:0] got,
                             output int n);
      got = 4'b0;
      n = 0;
      for (int k = 1; k <= budget; k++) begin
         tick();
         if (bus.barrel_start != 4'b0) begin
            got = bus.barrel_start;
            n = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      clear_slots();
      set_slot(1, 2'b01, 10'd4, 9'd437);
      game_active = 1'b1;
      over = 1'b0;
      rst = 1'b1;
      tick_n(3);
      checks++;
      if (dk_state !== 2'b00)
         $display("FAIL reset_dk got %b exp 00", dk_state);
      else passed++;
      checks++;
      if (bus.barrel_start !== 4'b0)
         $display("FAIL reset_start got %b exp 0000", bus.barrel_start);
      else passed++;
      checks++;
      if (bus.barrel_rst !== 4'b0)
         $display("FAIL reset_brst got %b exp 0000", bus.barrel_rst);
      else passed++;
      checks++;
      if (live_count !== 4'd0)
         $display("FAIL reset_live got %0d exp 0", live_count);
      else passed++;
      rst = 1'b0;
   endtask

   task automatic test_first_throw();
      do_reset();
      tick_n(119);
      checks++;
      if (dk_state !== 2'b00)
         $display("FAIL t1_idle119 got %b exp 00", dk_state);
      else passed++;
      tick();
      checks++;
      if (dk_state !== 2'b01)
         $display("FAIL t1_grab120 got %b exp 01", dk_state);
      else passed++;
      tick_n(15);
      checks++;
      if (bus.barrel_start !== 4'b0)
         $display("FAIL t1_start135 got %b exp 0000", bus.barrel_start);
      else passed++;
      tick();
      checks++;
      if (bus.barrel_start !== 4'b0001 || dk_state !== 2'b10)
         $display("FAIL t1_start136 got %b/%b exp 0001/10",
                  bus.barrel_start, dk_state);
      else passed++;
      tick();
      checks++;
      if (bus.barrel_start !== 4'b0)
         $display("FAIL t1_start137 got %b exp 0000", bus.barrel_start);
      else passed++;
      tick_n(14);
      checks++;
      if (dk_state !== 2'b10)
         $display("FAIL t1_throw151 got %b exp 10", dk_state);
      else passed++;
      tick();
      checks++;
      if (dk_state !== 2'b00)
         $display("FAIL t1_idle152 got %b exp 00", dk_state);
      else passed++;
   endtask

   task automatic test_four_throws();
      logic [3:0] got;
      int n;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         wait_start(200, got, n);
         checks++;
         if (got !== 4'(1 << k))
            $display("FAIL rr_slot%0d got %b exp %b", k, got, 4'(1 << k));
         else passed++;
         if (k > 0) begin
            checks++;
            if (n !== 152)
               $display("FAIL rr_period%0d got %0d exp 152", k, n);
            else passed++;
         end
         set_slot(k, 2'b01, 10'd100, 9'd100);
      end
      tick();
      checks++;
      if (live_count !== 4'd4)
         $display("FAIL rr_live got %0d exp 4", live_count);
      else passed++;
      wait_start(300, got, n);
      checks++;
      if (got !== 4'b0 || dk_state !== 2'b00)
         $display("FAIL rr_full got %b/%b exp 0000/00", got, dk_state);
      else passed++;
      set_slot(2, 2'b00, 10'd100, 9'd100);
      wait_start(40, got, n);
      checks++;
      if (got !== 4'b0100 || n !== 17)
         $display("FAIL rr_refill got %b@%0d exp 0100@17", got, n);
      else passed++;
   endtask

   task automatic test_retire();
      do_reset();
      set_slot(1, 2'b01, 10'd4, 9'd437);
      tick();
      checks++;
      if (bus.barrel_rst !== 4'b0010)
         $display("FAIL ret_hit got %b exp 0010", bus.barrel_rst);
      else passed++;
      set_slot(1, 2'b01, 10'd6, 9'd437);
      tick();
      checks++;
      if (bus.barrel_rst !== 4'b0)
         $display("FAIL ret_x6 got %b exp 0000", bus.barrel_rst);
      else passed++;
      set_slot(1, 2'b01, 10'd4, 9'd436);
      tick();
      checks++;
      if (bus.barrel_rst !== 4'b0)
         $display("FAIL ret_y436 got %b exp 0000", bus.barrel_rst);
      else passed++;
      set_slot(3, 2'b10, 10'd5, 9'd500);
      tick();
      checks++;
      if (bus.barrel_rst !== 4'b1000)
         $display("FAIL ret_edge got %b exp 1000", bus.barrel_rst);
      else passed++;
      set_slot(3, 2'b00, 10'd5, 9'd500);
      tick();
      checks++;
      if (bus.barrel_rst !== 4'b0)
         $display("FAIL ret_idle got %b exp 0000", bus.barrel_rst);
      else passed++;
   endtask

   task automatic test_abort();
      logic [3:0] seen;
      do_reset();
      tick_n(130);
      over = 1'b1;
      tick();
      checks++;
      if (dk_state !== 2'b00)
         $display("FAIL ab_idle got %b exp 00", dk_state);
      else passed++;
      seen = 4'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         seen = seen | bus.barrel_start;
      end
      checks++;
      if (seen !== 4'b0)
         $display("FAIL ab_nostart got %b exp 0000", seen);
      else passed++;
      over = 1'b0;
      tick_n(119);
      checks++;
      if (dk_state !== 2'b00)
         $display("FAIL ab_idle119 got %b exp 00", dk_state);
      else passed++;
      tick();
      checks++;
      if (dk_state !== 2'b01)
         $display("FAIL ab_grab120 got %b exp 01", dk_state);
      else passed++;
   endtask

   task automatic test_collision();
      do_reset();
      tick_n(135);
      set_slot(0, 2'b01, 10'd4, 9'd437);
      tick();
      checks++;
      if (bus.barrel_rst !== 4'b0001 || bus.barrel_start !== 4'b0)
         $display("FAIL col got rst %b start %b exp 0001/0000",
                  bus.barrel_rst, bus.barrel_start);
      else passed++;
      checks++;
      if (dk_state !== 2'b10)
         $display("FAIL col_throw got %b exp 10", dk_state);
      else passed++;
   endtask

   task automatic test_rst_mid();
      logic [3:0] got;
      int n;
      do_reset();
      tick_n(137);
      set_slot(2, 2'b01, 10'd4, 9'd437);
      tick();
      checks++;
      if (bus.barrel_rst !== 4'b0100 || dk_state !== 2'b10)
         $display("FAIL rm_pre got %b/%b exp 0100/10",
                  bus.barrel_rst, dk_state);
      else passed++;
      rst = 1'b1;
      tick();
      checks++;
      if (bus.barrel_rst !== 4'b0 || bus.barrel_start !== 4'b0 ||
          dk_state !== 2'b00 || live_count !== 4'd0)
         $display("FAIL rm_zero got %b %b %b %0d exp all 0",
                  bus.barrel_rst, bus.barrel_start, dk_state, live_count);
      else passed++;
      rst = 1'b0;
      clear_slots();
      wait_start(200, got, n);
      checks++;
      if (got !== 4'b0001 || n !== 136)
         $display("FAIL rm_ptr got %b@%0d exp 0001@136", got, n);
      else passed++;
   endtask

   initial begin
      rst = 1'b1;
      game_active = 1'b0;
      over = 1'b0;
      test_reset();
      test_first_throw();
      test_four_throws();
      test_retire();
      test_abort();
      test_collision();
      test_rst_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
